cnt_gen: RTL and testbench

CNT_GEN -- requirements
Module: cnt_gen

---
 rtl/cnt_gen.sv | 145 ++++++++++++++
 tb/tb_cnt_gen.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_gen.sv
// Prescaled counter / divider with WRAP, UPDOWN and ONESHOT modes.
// Optional PWM compare output when CNT_GEN_PWM_EN is defined.
module cnt_gen #(
  parameter int WIDTH      = 32,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [2:0]            mode,
  input  logic [WIDTH-1:0]      div,
  input  logic                  div_load,
  input  logic [PRESCALE_W-1:0] prescale,
`ifdef CNT_GEN_PWM_EN
  input  logic [WIDTH-1:0]      cmp,
  output logic                  pwm,
`endif
  output logic                  q,
  output logic                  tc,
  output logic [WIDTH-1:0]      dout
);

  localparam logic [1:0] M_OFF  = 2'd0;
  localparam logic [1:0] M_WRAP = 2'd1;
  localparam logic [1:0] M_UPDN = 2'd2;
  localparam logic [1:0] M_ONE  = 2'd3;

  localparam logic [WIDTH-1:0]      D_ONE = WIDTH'(1);
  localparam logic [PRESCALE_W-1:0] P_ONE = PRESCALE_W'(1);

  logic [WIDTH-1:0]      data, data_n, divider;
  logic [PRESCALE_W-1:0] psc, psc_n;
  logic                  phase_dn, phase_n, done, done_n, q_n, tc_n, tick;
  logic [1:0]            mode_r, mode_eff;

  // 1xx folds onto OFF so it never looks like a mode change against OFF
  assign mode_eff = mode[2] ? M_OFF : mode[1:0];
  assign tick     = (psc == prescale);

  always_comb begin
    data_n  = data;
    psc_n   = psc;
    phase_n = phase_dn;
    done_n  = done;
    q_n     = q;
    tc_n    = 1'b0;
    if (mode_eff != mode_r) begin
      data_n  = '0;
      psc_n   = '0;
      phase_n = 1'b0;
      done_n  = 1'b0;
    end else if (div_load && mode_eff == M_ONE) begin
      // re-arm the one-shot
      data_n = '0;
      done_n = 1'b0;
      q_n    = 1'b0;
    end else if (en) begin
      if (mode_eff == M_OFF) begin
        data_n  = '0;
        psc_n   = '0;
        phase_n = 1'b0;
      end else begin
        psc_n = tick ? '0 : psc + P_ONE;
        if (tick) begin
          case (mode_eff)
            M_WRAP: begin
              if (data >= divider) begin
                data_n = '0;
                q_n    = ~q;
                tc_n   = 1'b1;
              end else begin
                data_n = data + D_ONE;
              end
            end
            M_UPDN: begin
              if (!phase_dn) begin
                if (data >= divider) begin
                  phase_n = 1'b1;
                  q_n     = ~q;
                  tc_n    = 1'b1;
                  data_n  = (divider == '0) ? '0 : divider - D_ONE;
                end else begin
                  data_n = data + D_ONE;
                end
              end else begin
                if (data == '0) begin
                  phase_n = 1'b0;
                  q_n     = ~q;
                  tc_n    = 1'b1;
                  data_n  = (divider == '0) ? '0 : D_ONE;
                end else begin
                  data_n = data - D_ONE;
                end
              end
            end
            M_ONE: begin
              if (!done) begin
                if (data >= divider) begin
                  data_n = divider;
                  q_n    = 1'b1;
                  tc_n   = 1'b1;
                  done_n = 1'b1;
                end else begin
                  data_n = data + D_ONE;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data     <= '0;
      divider  <= '0;
      psc      <= '0;
      phase_dn <= 1'b0;
      done     <= 1'b0;
      mode_r   <= M_OFF;
      q        <= 1'b0;
      tc       <= 1'b0;
`ifdef CNT_GEN_PWM_EN
      pwm      <= 1'b0;
`endif
    end else begin
      data     <= data_n;
      psc      <= psc_n;
      phase_dn <= phase_n;
      done     <= done_n;
      mode_r   <= mode_eff;
      q        <= q_n;
      tc       <= tc_n;
      if (div_load) divider <= div;
`ifdef CNT_GEN_PWM_EN
      pwm      <= (mode_eff != M_OFF) && (data_n < cmp);
`endif
    end
  end

  assign dout = data;

endmodule

// File: tb/tb_cnt_gen.sv
// Self-checking bench for cnt_gen: directed sequences with fixed expectations
// plus randomized traffic against a behavioural model.
module tb_cnt_gen;
  localparam int W    = 8;
  localparam int PW   = 4;
  localparam int MODW = 1 << W;
  localparam int MODP = 1 << PW;

  logic          clk = 1'b0;
  logic          reset, en, div_load;
  logic [2:0]    mode;
  logic [W-1:0]  div;
  logic [PW-1:0] prescale;
  logic          q, tc;
  logic [W-1:0]  dout;
`ifdef CNT_GEN_PWM_EN
  logic [W-1:0]  cmp;
  logic          pwm;
`endif

  cnt_gen #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .div(div),
    .div_load(div_load), .prescale(prescale),
`ifdef CNT_GEN_PWM_EN
    .cmp(cmp), .pwm(pwm),
`endif
    .q(q), .tc(tc), .dout(dout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference state, plain integers
  int m_data, m_div, m_psc, m_mode, m_q, m_tc, m_pwm;
  bit m_going_up, m_done;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Compute the next reference state from the inputs presented this cycle.
  task automatic model_step();
    int  md, nd;
    bit  terminal;
    md = (mode > 3) ? 0 : int'(mode);
    if (reset) begin
      m_data = 0; m_div = 0; m_psc = 0; m_mode = 0;
      m_going_up = 1; m_done = 0; m_q = 0; m_tc = 0; m_pwm = 0;
      return;
    end
    m_tc = 0;
    if (md != m_mode) begin
      m_data = 0; m_psc = 0; m_going_up = 1; m_done = 0;
    end else if (div_load && md == 3) begin
      m_data = 0; m_done = 0; m_q = 0;
    end else if (en && md == 0) begin
      m_data = 0; m_psc = 0; m_going_up = 1;
    end else if (en) begin
      if (m_psc == int'(prescale)) begin
        m_psc = 0;
        terminal = 0;
        nd = m_data;
        if (md == 1) begin
          terminal = (m_data >= m_div);
          nd = terminal ? 0 : (m_data + 1) % MODW;
        end else if (md == 2 && m_going_up) begin
          terminal = (m_data >= m_div);
          nd = terminal ? (m_div == 0 ? 0 : m_div - 1) : (m_data + 1) % MODW;
          if (terminal) m_going_up = 0;
        end else if (md == 2) begin
          terminal = (m_data == 0);
          nd = terminal ? (m_div == 0 ? 0 : 1) : m_data - 1;
          if (terminal) m_going_up = 1;
        end else if (!m_done) begin
          terminal = (m_data >= m_div);
          nd = terminal ? m_div : (m_data + 1) % MODW;
          if (terminal) begin m_done = 1; m_q = 0; end
        end
        m_data = nd;
        if (terminal) begin
          m_tc = 1;
          m_q  = (md == 3) ? 1 : 1 - m_q;
        end
      end else begin
        m_psc = (m_psc + 1) % MODP;
      end
    end
`ifdef CNT_GEN_PWM_EN
    m_pwm = (md != 0 && m_data < int'(cmp)) ? 1 : 0;
`endif
    m_mode = md;
    if (div_load) m_div = int'(div);
  endtask

  task automatic cyc(input bit r, input bit e, input int m, input int d, input bit dl, input int ps);
    @(negedge clk);
    reset = r; en = e; mode = m[2:0]; div = d[W-1:0]; div_load = dl; prescale = ps[PW-1:0];
`ifdef CNT_GEN_PWM_EN
    cmp = 8'($urandom_range(0, 12));
`endif
    model_step();
    @(posedge clk);
    #1;
    check("dout", dout, m_data);
    check("q", q, m_q);
    check("tc", tc, m_tc);
`ifdef CNT_GEN_PWM_EN
    check("pwm", pwm, m_pwm);
`endif
  endtask

  int exp_d[8], exp_t[8];
  int tc_cnt, cur_mode, cur_ps, cur_div;

  initial begin
    reset = 1; en = 0; mode = 0; div = 0; div_load = 0; prescale = 0;
`ifdef CNT_GEN_PWM_EN
    cmp = 0;
`endif
    m_data = 0; m_div = 0; m_psc = 0; m_mode = 0; m_q = 0; m_tc = 0; m_pwm = 0;
    m_going_up = 1; m_done = 0;

    // reset overrides everything else
    cyc(1, 1, 1, 9, 1, 0);
    cyc(1, 1, 2, 9, 1, 0);
    check("rst_dout", dout, 0);
    check("rst_q", q, 0);
    check("rst_tc", tc, 0);

    // WRAP div=3
    cyc(0, 1, 1, 3, 1, 0);
    exp_d = '{1, 2, 3, 0, 1, 2, 3, 0};
    exp_t = '{0, 0, 0, 1, 0, 0, 0, 1};
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 1, 3, 0, 0);
      check("wrap_seq", dout, exp_d[i]);
      check("wrap_tc", tc, exp_t[i]);
      if (i == 3) check("wrap_q1", q, 1);
    end
    check("wrap_q0", q, 0);

    // UPDOWN div=2
    cyc(0, 1, 2, 2, 1, 0);
    exp_d = '{1, 2, 1, 0, 1, 2, 1, 0};
    exp_t = '{0, 0, 1, 0, 1, 0, 1, 0};
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 2, 2, 0, 0);
      check("updn_seq", dout, exp_d[i]);
      check("updn_tc", tc, exp_t[i]);
    end

    // WRAP div=1 prescale=2, then freeze with en=0
    cyc(0, 1, 1, 1, 1, 2);
    exp_d = '{0, 0, 1, 1, 1, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 1, 1, 0, 2);
      check("psc_seq", dout, exp_d[i]);
    end
    cyc(0, 1, 1, 1, 0, 2);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 1, 0, 2);
      check("freeze", dout, 1);
    end
    for (int i = 0; i < 6; i++) cyc(0, 1, 1, 1, 0, 2);

    // ONESHOT div=4, then re-arm with div=2
    cyc(0, 1, 3, 4, 1, 0);
    tc_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 3, 4, 0, 0);
      if (tc) tc_cnt++;
    end
    check("one_tc_cnt", tc_cnt, 1);
    check("one_hold", dout, 4);
    check("one_q", q, 1);
    cyc(0, 1, 3, 2, 1, 0);
    check("rearm_d", dout, 0);
    check("rearm_q", q, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 3, 2, 0, 0);
    check("rearm_hold", dout, 2);
    check("rearm_q1", q, 1);

    // WRAP div=10, shrink divider mid-count, then reset mid-count
    cyc(0, 1, 1, 10, 1, 0);
    for (int i = 0; i < 7; i++) cyc(0, 1, 1, 10, 0, 0);
    check("shrink_at7", dout, 7);
    cyc(0, 1, 1, 5, 1, 0);
    cyc(0, 1, 1, 5, 0, 0);
    check("shrink_d", dout, 0);
    check("shrink_tc", tc, 1);
    cyc(0, 1, 1, 5, 0, 0);
    cyc(1, 1, 1, 5, 0, 0);
    check("midrst_d", dout, 0);
    check("midrst_tc", tc, 0);
    // divider is 0 after reset: every tick is terminal
    cyc(0, 1, 1, 5, 0, 0);
    cyc(0, 1, 1, 5, 0, 0);
    check("div0_tc", tc, 1);

    // randomized traffic
    cur_mode = 1; cur_ps = 0; cur_div = 3;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 31) == 0) cur_mode = $urandom_range(0, 7);
      if ($urandom_range(0, 63) == 0) cur_ps = $urandom_range(0, 3);
      cur_div = $urandom_range(0, 12);
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 4) != 0, cur_mode,
          cur_div, $urandom_range(0, 15) == 0, cur_ps);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
